// File: rtl/complex_to_pixel_if.sv
// Request/response bundle for the complex-to-pixel engine: point in, pixel out.
interface complex_to_pixel_if #(
  parameter int WORD_LENGTH = 32
);
  logic                          in_valid;
  logic                          in_ready;
  logic signed [WORD_LENGTH-1:0] in_re;
  logic signed [WORD_LENGTH-1:0] in_im;
  logic                          out_valid;
  logic                          out_ready;
  logic [10:0]                   out_x;
  logic [10:0]                   out_y;
  logic                          out_inside;

  modport master (
    output in_valid, in_re, in_im, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_inside
  );
  modport slave (
    input  in_valid, in_re, in_im, out_ready,
    output in_ready, out_valid, out_x, out_y, out_inside
  );
endinterface

// File: rtl/complex_to_pixel.sv
// Maps a complex point back to the screen pixel it falls in under the current view,
// using one shared restoring divider run twice (x then y).
module complex_to_pixel #(
  parameter int WORD_LENGTH   = 32,
  parameter int FRAC          = 28,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   zoom,
  input  logic signed [WORD_LENGTH-1:0] real_center,
  input  logic signed [WORD_LENGTH-1:0] imag_center,
  complex_to_pixel_if.slave             bus
);
  // One guard bit past WORD_LENGTH+1 so extreme centres cannot wrap the offsets.
  localparam int OW = WORD_LENGTH + 2;
  localparam int DW = WORD_LENGTH + 12;
  localparam logic signed [OW-1:0] SPAN_W = OW'(3) <<< FRAC;
  localparam logic signed [OW-1:0] SPAN_H = OW'(2) <<< FRAC;

  typedef enum logic [2:0] {IDLE, SETUP, DIV_X, DIV_Y, DONE} state_t;
  state_t state, nxt;

  logic signed [OW-1:0] width_c, height_c, real_min_c, imag_max_c;
  logic signed [OW-1:0] re_r, im_r, rmin_r, imax_r, width_r, height_r, oy_r;
  logic signed [OW-1:0] ox_c, oy_c;
  logic                 inside_c, accept, ready, ge, div_last;
  logic [DW-1:0]        rem, dsh;
  logic [10:0]          quo, q_next;
  logic [3:0]           cnt;
  logic [10:0]          x_r, y_r;
  logic                 inside_r;

  assign width_c    = SPAN_W >>> zoom;
  assign height_c   = SPAN_H >>> zoom;
  assign real_min_c = OW'(real_center) - (width_c >>> 1);
  assign imag_max_c = OW'(imag_center) + (height_c >>> 1);

  assign ox_c     = re_r - rmin_r;
  assign oy_c     = imax_r - im_r;
  assign inside_c = !ox_c[OW-1] && (ox_c < width_r) && !oy_c[OW-1] && (oy_c < height_r)
                    && (width_r != '0) && (height_r != '0);

  assign accept   = bus.in_valid && ready;
  assign ge       = rem >= dsh;
  assign q_next   = {quo[9:0], ge};
  assign div_last = cnt == 4'd10;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) nxt = SETUP;
      SETUP:   nxt = inside_c ? DIV_X : DONE;
      DIV_X:   if (div_last) nxt = DIV_Y;
      DIV_Y:   if (div_last) nxt = DONE;
      DONE:    if (bus.out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ready     = state == IDLE;
    bus.out_valid = state == DONE;
  end
  assign bus.in_ready   = ready;
  assign bus.out_x      = x_r;
  assign bus.out_y      = y_r;
  assign bus.out_inside = inside_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      re_r <= '0; im_r <= '0; rmin_r <= '0; imax_r <= '0;
      width_r <= '0; height_r <= '0; oy_r <= '0;
      rem <= '0; dsh <= '0; quo <= '0; cnt <= '0;
      x_r <= '0; y_r <= '0; inside_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          re_r     <= OW'(bus.in_re);
          im_r     <= OW'(bus.in_im);
          rmin_r   <= real_min_c;
          imax_r   <= imag_max_c;
          width_r  <= width_c;
          height_r <= height_c;
        end
        SETUP: begin
          inside_r <= inside_c;
          x_r      <= '0;
          y_r      <= '0;
          oy_r     <= oy_c;
          rem      <= DW'(ox_c) * DW'(SCREEN_WIDTH);
          dsh      <= DW'(width_r) << 10;
          quo      <= '0;
          cnt      <= '0;
        end
        DIV_X, DIV_Y: begin
          if (ge) rem <= rem - dsh;
          dsh <= dsh >> 1;
          quo <= q_next;
          cnt <= cnt + 4'd1;
          // Quotient fits in 11 bits because inside bounds the offset below the span.
          if (div_last) begin
            if (state == DIV_X) begin
              x_r <= q_next;
              rem <= DW'(oy_r) * DW'(SCREEN_HEIGHT);
              dsh <= DW'(height_r) << 10;
              quo <= '0;
              cnt <= '0;
            end else begin
              y_r <= q_next;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_to_pixel.sv
// Directed bench for complex_to_pixel: hand-computed pixels, latency, stall and reset cases.
module tb_complex_to_pixel;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] zoom;
  logic signed [31:0] real_center, imag_center;
  int n_chk = 0;
  int n_fail = 0;

  complex_to_pixel_if #(.WORD_LENGTH(32)) bus ();

  complex_to_pixel #(.WORD_LENGTH(32), .FRAC(28), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480)) dut (
    .clk(clk), .rst(rst), .zoom(zoom), .real_center(real_center),
    .imag_center(imag_center), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Counts negedges after the accept edge until out_valid is seen.
  task automatic wait_valid(input string tag, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 100);
    check({tag, "_reached"}, {31'd0, bus.out_valid}, 32'd1);
  endtask

  task automatic do_req(input string tag, input logic [31:0] re, input logic [31:0] im,
                        input int exp_lat, input logic [10:0] ex, input logic [10:0] ey,
                        input logic ein, input bit perturb);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1; bus.in_re = re; bus.in_im = im;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    if (perturb) begin zoom = 32'd3; real_center = 32'h1234_5678; imag_center = 32'h0800_0000; end
    wait_valid(tag, lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_x"}, {21'd0, bus.out_x}, {21'd0, ex});
    check({tag, "_y"}, {21'd0, bus.out_y}, {21'd0, ey});
    check({tag, "_in"}, {31'd0, bus.out_inside}, {31'd0, ein});
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check({tag, "_hs_ov"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_hs_rdy"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int lat, seen;
    rst = 1'b1; zoom = '0; real_center = 32'hF800_0000; imag_center = '0;
    bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", {31'd0, bus.in_ready}, 32'd1);
    check("rst_ov",  {31'd0, bus.out_valid}, 32'd0);
    check("rst_x",   {21'd0, bus.out_x}, 32'd0);
    check("rst_y",   {21'd0, bus.out_y}, 32'd0);
    check("rst_in",  {31'd0, bus.out_inside}, 32'd0);
    rst = 1'b0;

    // View: centre (-0.5,0), zoom 0 -> real_min=-2.0, imag_max=1.0, span 3.0 x 2.0
    do_req("corner",   32'hE000_0000, 32'h1000_0000, 24, 11'd0,   11'd0,   1'b1, 1'b0);
    do_req("origin",   32'h0000_0000, 32'h0000_0000, 24, 11'd426, 11'd240, 1'b1, 1'b0);
    do_req("mid",      32'h0800_0000, 32'hFC00_0000, 24, 11'd533, 11'd300, 1'b1, 1'b0);
    do_req("lastpix",  32'h0FFF_FFFF, 32'hF000_0001, 24, 11'd639, 11'd479, 1'b1, 1'b0);
    do_req("right_ex", 32'h1000_0000, 32'h0000_0000, 2,  11'd0,   11'd0,   1'b0, 1'b0);
    do_req("bot_ex",   32'hE000_0000, 32'hF000_0000, 2,  11'd0,   11'd0,   1'b0, 1'b0);
    do_req("left_out", 32'hDFFF_FFFF, 32'h0000_0000, 2,  11'd0,   11'd0,   1'b0, 1'b0);

    // Zoom 1 about the origin, with the view changed while the request is in flight
    zoom = 32'd1; real_center = '0; imag_center = '0;
    do_req("zoom1",    32'h0000_0000, 32'h0000_0000, 24, 11'd320, 11'd240, 1'b1, 1'b1);

    // Span shifted to zero
    zoom = 32'd40; real_center = '0; imag_center = '0;
    do_req("zero_span", 32'h0000_0000, 32'h0000_0000, 2, 11'd0, 11'd0, 1'b0, 1'b0);

    // Consumer stall in DONE with a competing request
    zoom = '0; real_center = 32'hF800_0000; imag_center = '0;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_re = '0; bus.in_im = '0;
    @(posedge clk);
    #1 bus.in_re = 32'h0800_0000; bus.in_im = 32'hFC00_0000;
    wait_valid("stall", lat);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.out_x != 11'd426 || bus.out_y != 11'd240) seen++;
    end
    check("stall_hold", seen, 0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("stall_rdy", {31'd0, bus.in_ready}, 32'd1);
    check("stall_ov",  {31'd0, bus.out_valid}, 32'd0);

    // Reset in the middle of DIV_X abandons the request
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_re = '0; bus.in_im = '0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_rdy", {31'd0, bus.in_ready}, 32'd1);
    check("mid_rst_ov",  {31'd0, bus.out_valid}, 32'd0);
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("mid_rst_quiet", seen, 0);
    do_req("after_rst", 32'h0000_0000, 32'h0000_0000, 24, 11'd426, 11'd240, 1'b1, 1'b0);

    // Reset wins over a simultaneous accept
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; bus.in_valid = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.out_valid || !bus.in_ready) seen++;
    end
    check("rst_vs_acc", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
